// File: rtl/ahb_sub_mux.sv
`default_nettype none
// ============================================================================
//  Module      : ahb_sub_mux
//  Description : AHB read-data / response multiplexer with an integrated
//                default subordinate. Registers the decoder's one-hot
//                address-phase select into a data-phase select and forwards
//                the selected subordinate's ready/resp/exOkay/rData back to
//                the manager. Transfers with an invalid select (none set, or
//                more than one set) get the two-cycle ERROR response.
//  Ports       : clk_i            clock
//                nReset_i         asynchronous active-low reset
//                sel_i            one-hot address-phase select
//                trans_i          HTRANS (bit 1 = active transfer)
//                subReadyOut_i    per-subordinate readyOut
//                subResp_i        per-subordinate resp (1 = ERROR)
//                subExOkay_i      per-subordinate exOkay
//                subRData_i       packed read data, slot i at [i*DW +: DW]
//                ready_o          shared transfer-complete
//                resp_o           shared response (1 = ERROR)
//                exOkay_o         shared exclusive status
//                rData_o          shared read data
//  Option      : AHB_SUB_MUX_ERR_LOG_EN adds addr_i, errAddr_o and
//                errCount_o (saturating count of default-subordinate errors,
//                address of the most recent one).
//  Revision    : 1.0 - initial release
// ============================================================================
module ahb_sub_mux #(
  parameter int DATA_WIDTH = 32,
`ifdef AHB_SUB_MUX_ERR_LOG_EN
  parameter int ADDR_WIDTH = 32,
`endif
  parameter int NUM_SUBS   = 4
) (
  input  logic                           clk_i,
  input  logic                           nReset_i,
  input  logic [NUM_SUBS-1:0]            sel_i,
  input  logic [2:0]                     trans_i,
  input  logic [NUM_SUBS-1:0]            subReadyOut_i,
  input  logic [NUM_SUBS-1:0]            subResp_i,
  input  logic [NUM_SUBS-1:0]            subExOkay_i,
  input  logic [NUM_SUBS*DATA_WIDTH-1:0] subRData_i,
`ifdef AHB_SUB_MUX_ERR_LOG_EN
  input  logic [ADDR_WIDTH-1:0]          addr_i,
  output logic [ADDR_WIDTH-1:0]          errAddr_o,
  output logic [7:0]                     errCount_o,
`endif
  output logic                           ready_o,
  output logic                           resp_o,
  output logic                           exOkay_o,
  output logic [DATA_WIDTH-1:0]          rData_o
);

  localparam logic [1:0] c_ST_IDLE = 2'd0;
  localparam logic [1:0] c_ST_ERR1 = 2'd1;
  localparam logic [1:0] c_ST_ERR2 = 2'd2;

  localparam logic [NUM_SUBS-1:0] c_ONE = NUM_SUBS'(1);

  logic [1:0]          state_q, state_d;
  logic [NUM_SUBS-1:0] dataSel_q, dataSel_d;

  logic active;
  logic valid;
  logic unused_trans;

  // Only NONSEQ/SEQ (bit 1) start a transfer; bits 0 and 2 carry no meaning here.
  assign active       = trans_i[1];
  assign unused_trans = trans_i[2] ^ trans_i[0];

  // Exactly one bit set: non-zero and clearing the lowest set bit leaves zero.
  assign valid = (sel_i != '0) && ((sel_i & (sel_i - c_ONE)) == '0);

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge nReset_i) begin
    if (!nReset_i) begin
      state_q   <= c_ST_IDLE;
      dataSel_q <= '0;
    end else begin
      state_q   <= state_d;
      dataSel_q <= dataSel_d;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic. The address phase is only accepted while the shared
  // ready is high; ERR1 drives ready low, so it always advances to ERR2.
  // --------------------------------------------------------------------------
  always_comb begin
    state_d   = state_q;
    dataSel_d = dataSel_q;
    case (state_q)
      c_ST_ERR1: begin
        state_d = c_ST_ERR2;
      end
      c_ST_IDLE, c_ST_ERR2: begin
        if (ready_o) begin
          if (active && valid) begin
            state_d   = c_ST_IDLE;
            dataSel_d = sel_i;
          end else if (active) begin
            state_d   = c_ST_ERR1;
            dataSel_d = '0;
          end else begin
            state_d   = c_ST_IDLE;
            dataSel_d = '0;
          end
        end
      end
      default: begin
        state_d   = c_ST_IDLE;
        dataSel_d = '0;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Output logic. dataSel_q is at most one-hot, so the loop acts as a mux;
  // with no slot selected the default subordinate answers zero-wait OKAY.
  // --------------------------------------------------------------------------
  always_comb begin
    ready_o  = 1'b1;
    resp_o   = 1'b0;
    exOkay_o = 1'b0;
    rData_o  = '0;
    case (state_q)
      c_ST_ERR1: begin
        ready_o = 1'b0;
        resp_o  = 1'b1;
      end
      c_ST_ERR2: begin
        ready_o = 1'b1;
        resp_o  = 1'b1;
      end
      c_ST_IDLE: begin
        for (int i = 0; i < NUM_SUBS; i++) begin
          if (dataSel_q[i]) begin
            ready_o  = subReadyOut_i[i];
            resp_o   = subResp_i[i];
            exOkay_o = subExOkay_i[i];
            rData_o  = subRData_i[i*DATA_WIDTH +: DATA_WIDTH];
          end
        end
      end
      default: begin
        ready_o = 1'b1;
      end
    endcase
  end

`ifdef AHB_SUB_MUX_ERR_LOG_EN
  logic [ADDR_WIDTH-1:0] errAddr_q;
  logic [7:0]            errCount_q;

  // Every ERR1 entry comes from an accepted invalid address phase, so addr_i
  // is sampled in exactly the cycle that caused the error.
  always_ff @(posedge clk_i or negedge nReset_i) begin
    if (!nReset_i) begin
      errAddr_q  <= '0;
      errCount_q <= 8'd0;
    end else if (state_d == c_ST_ERR1) begin
      errAddr_q <= addr_i;
      if (errCount_q != 8'hFF) begin
        errCount_q <= errCount_q + 8'd1;
      end
    end
  end

  assign errAddr_o  = errAddr_q;
  assign errCount_o = errCount_q;
`endif

endmodule
`default_nettype wire

// File: doc/ahb_sub_mux.md
Name: ahb_sub_mux

Overview:
- AHB read-data/response multiplexer with an integrated default subordinate.
- Implements the mux role of the common AHB interface: it consumes per-subordinate readyOut/resp/rData/exOkay and drives the shared ready, resp, rData and exOkay back to the manager and all subordinates.
- Registers the decoder's address-phase one-hot select into a data-phase select.
- Answers unmapped or invalid selects with the protocol two-cycle ERROR response.

Parameters:
- DataWidth, 32, bit-width of read data
- AddrWidth, 32, bit-width of address (used only with the optional feature)
- NumSubs, 4, number of subordinate slots (≥1)

Ports:
- clk  input  1  clock
- nReset  input  1  asynchronous active-low reset
- sel  input  NumSubs  one-hot address-phase select from decoder
- trans  input  3  transfer type; bits [1:0]: 00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ; bit 2 ignored
- subReadyOut  input  NumSubs  per-subordinate readyOut
- subResp  input  NumSubs  per-subordinate resp (1 = ERROR)
- subExOkay  input  NumSubs  per-subordinate exOkay
- subRData  input  NumSubs*DataWidth  packed read data, slot i at [i*DataWidth +: DataWidth]
- ready  output  1  shared transfer-complete signal
- resp  output  1  shared response (1 = ERROR)
- exOkay  output  1  shared exclusive status
- rData  output  DataWidth  shared read data

Behaviour:
- Clock and reset: single clock clk; nReset is asynchronous, active-low.
- Reset state:
  - dataSel=0, FSM=IDLE.
  - Outputs ready=1, resp=0, exOkay=0, rData=0.
  - Takes effect immediately on nReset assertion, including mid-transfer or mid-error.
- Address-phase sampling occurs on rising clk only when ready==1.
  - active = trans[1].
  - valid = sel is exactly one-hot.
  - If active && valid: dataSel<=sel, FSM stays IDLE (forwarding).
  - If active && !valid (zero or multiple bits set): dataSel<=0, FSM->ERR1.
  - If !active (IDLE/BUSY): dataSel<=0, FSM stays IDLE. The default response is zero-wait OKAY.
- When ready==0, dataSel and any new address phase are held. sel and trans are ignored.
- Data-phase outputs are combinational from registered state:
  - Forwarding (dataSel bit i set): ready=subReadyOut[i], resp=subResp[i], exOkay=subExOkay[i], rData=slice i.
  - IDLE with dataSel==0: ready=1, resp=0, exOkay=0, rData=0.
  - ERR1: ready=0, resp=1, exOkay=0, rData=0. Next state is ERR2 unconditionally.
  - ERR2: ready=1, resp=1, exOkay=0, rData=0. The address phase is sampled this cycle per the rules above, so back-to-back errors give ERR2->ERR1.
- FSM states: IDLE, ERR1, ERR2. No other transitions exist.
- A subordinate error is passed through unaltered. The mux does not stretch or generate it.
- Latency:
  - Select-to-output is one clk (registered).
  - Subordinate-to-output is zero cycles (combinational).
- Unused bits of dataSel never assert. NumSubs=1 is legal.

Optional Feature:
- Macro AHB_SUB_MUX_ERR_LOG_EN.
- When defined, adds ports:
  - addr  input  AddrWidth
  - errAddr  output  AddrWidth
  - errCount  output  8
- On each entry to ERR1, errAddr captures the addr sampled in that address phase.
- errCount increments on each entry to ERR1 and saturates at 255.
- Both reset to 0.
- When undefined, these ports and registers do not exist and behaviour is otherwise identical.

Test Plan:
- Reset check: assert nReset=0 mid-forward → ready=1, resp=0, rData=0, exOkay=0 immediately. After release, the first IDLE cycle gives ready=1.
- Basic forward: sel=4'b0100, trans=NONSEQ with ready=1; next cycle subRData slot2=32'hDEADBEEF, subReadyOut[2]=1 → rData=32'hDEADBEEF, ready=1, resp=0.
- Wait-state hold: slot1 selected with subReadyOut[1]=0 for 3 cycles while sel changes to 4'b0001 → ready=0 for 3 cycles and dataSel stays slot1. The new select is taken only after ready=1.
- Unmapped address: sel=0, trans=SEQ → next cycle ready=0/resp=1, then ready=1/resp=1, then IDLE. Repeat with sel=4'b0011 and require the same response.
- Back-to-back errors: two unmapped NONSEQ in a row → sequence ERR1,ERR2,ERR1,ERR2. With the macro, errCount=2 and errAddr = the second address. Also drive 300 errors → errCount=255.
- IDLE/BUSY: trans=IDLE with sel=4'b1000 → next cycle ready=1, resp=0, rData=0, and subordinate 3 outputs are ignored.
